// File: rtl/note_lane_engine.sv
// Falling-note slot engine: spawn handshake, frame-tick motion and retirement, strum hit resolution, per-lane draw query.
// Define NOTE_ENGINE_SCORE_EN to build the saturating hit-score register; otherwise o_score is tied to zero.
module note_lane_engine #(
    parameter int LANES    = 4,
    parameter int SLOTS    = 4,
    parameter int Y_WIDTH  = 10,
    parameter int SCREEN_H = 480,
    parameter int SPAWN_Y  = 0,
    parameter int NOTE_H   = 50,
    parameter int HIT_Y    = 350,
    parameter int HIT_H    = 20,
    parameter int SPEED    = 1
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_frame_tick,
    input  logic               i_spawn_valid,
    input  logic [LANES-1:0]   i_spawn_mask,
    output logic               o_spawn_ready,
    input  logic [LANES-1:0]   i_strum,
    input  logic [Y_WIDTH-1:0] i_pix_y,
    output logic [LANES-1:0]   o_lane_draw,
    output logic [LANES-1:0]   o_hit_pulse,
    output logic [LANES-1:0]   o_miss_pulse,
    output logic [15:0]        o_score
);
    localparam int YW1 = Y_WIDTH + 1;
    localparam logic [Y_WIDTH:0]   C_SPEED    = YW1'(SPEED);
    localparam logic [Y_WIDTH:0]   C_SCREEN_H = YW1'(SCREEN_H);
    localparam logic [Y_WIDTH:0]   C_NOTE_H   = YW1'(NOTE_H);
    localparam logic [Y_WIDTH:0]   C_HIT_Y    = YW1'(HIT_Y);
    localparam logic [Y_WIDTH:0]   C_HIT_END  = YW1'(HIT_Y + HIT_H);
    localparam logic [Y_WIDTH-1:0] C_SPAWN_Y  = Y_WIDTH'(SPAWN_Y);

    if (SCREEN_H + SPEED >= (1 << Y_WIDTH)) begin : g_bad_cfg
        $error("note_lane_engine: SCREEN_H+SPEED must be below 2**Y_WIDTH");
    end

    logic [SLOTS-1:0]   r_valid [LANES];
    logic [Y_WIDTH-1:0] r_y     [LANES][SLOTS];
    logic [LANES-1:0]   r_hit;
    logic [LANES-1:0]   r_miss;
    logic [LANES-1:0]   r_draw;

    logic [SLOTS-1:0]   w_valid_nx [LANES];
    logic [Y_WIDTH-1:0] w_y_nx     [LANES][SLOTS];
    logic [LANES-1:0]   w_hit_nx;
    logic [LANES-1:0]   w_miss_nx;
    logic [LANES-1:0]   w_draw_nx;
    logic [LANES-1:0]   w_lane_free;
    logic               w_spawn;
    logic [Y_WIDTH:0]   w_pix;

    // Per-lane free-slot summary drives the spawn handshake.
    always_comb begin
        w_lane_free = '0;
        for (int l = 0; l < LANES; l++) begin
            w_lane_free[l] = ~&r_valid[l];
        end
    end

    assign o_spawn_ready = &w_lane_free;
    assign w_spawn       = i_spawn_valid & o_spawn_ready;
    assign w_pix         = {1'b0, i_pix_y};

    // Next slot state: hit beats move/retire, spawns only fill slots free before the cycle.
    always_comb begin
        logic               w_found;
        logic               w_free_found;
        logic [Y_WIDTH:0]   w_best;
        logic [Y_WIDTH:0]   w_ye;
        logic [Y_WIDTH:0]   w_mv;
        logic [SLOTS-1:0]   w_sel;
        logic [SLOTS-1:0]   w_free;
        w_valid_nx   = r_valid;
        w_y_nx       = r_y;
        w_hit_nx     = '0;
        w_miss_nx    = '0;
        w_draw_nx    = '0;
        w_found      = 1'b0;
        w_free_found = 1'b0;
        w_best       = '0;
        w_ye         = '0;
        w_mv         = '0;
        w_sel        = '0;
        w_free       = '0;
        for (int l = 0; l < LANES; l++) begin
            w_found      = 1'b0;
            w_free_found = 1'b0;
            w_best       = '0;
            w_sel        = '0;
            w_free       = '0;
            for (int s = 0; s < SLOTS; s++) begin
                w_ye = {1'b0, r_y[l][s]};
                // Strictly-greater keeps the lowest index on equal y.
                if (r_valid[l][s] && (w_ye + C_NOTE_H > C_HIT_Y) && (w_ye < C_HIT_END)
                    && (!w_found || (w_ye > w_best))) begin
                    w_found  = 1'b1;
                    w_best   = w_ye;
                    w_sel    = '0;
                    w_sel[s] = 1'b1;
                end else begin
                    w_found = w_found;
                end
                if (!r_valid[l][s] && !w_free_found) begin
                    w_free_found = 1'b1;
                    w_free[s]    = 1'b1;
                end else begin
                    w_free_found = w_free_found;
                end
                if (r_valid[l][s] && (w_ye <= w_pix) && (w_pix < w_ye + C_NOTE_H)) begin
                    w_draw_nx[l] = 1'b1;
                end else begin
                    w_draw_nx[l] = w_draw_nx[l];
                end
            end
            w_hit_nx[l] = i_strum[l] & w_found;
            for (int s = 0; s < SLOTS; s++) begin
                w_mv = {1'b0, r_y[l][s]} + C_SPEED;
                if (w_hit_nx[l] && w_sel[s]) begin
                    w_valid_nx[l][s] = 1'b0;
                end else if (i_frame_tick && r_valid[l][s]) begin
                    if (w_mv >= C_SCREEN_H) begin
                        w_valid_nx[l][s] = 1'b0;
                        w_miss_nx[l]     = 1'b1;
                    end else begin
                        w_y_nx[l][s] = w_mv[Y_WIDTH-1:0];
                    end
                end else if (w_spawn && i_spawn_mask[l] && w_free[s]) begin
                    w_valid_nx[l][s] = 1'b1;
                    w_y_nx[l][s]     = C_SPAWN_Y;
                end else begin
                    w_valid_nx[l][s] = w_valid_nx[l][s];
                end
            end
        end
    end

    // Slot state and registered lane outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int l = 0; l < LANES; l++) begin
                r_valid[l] <= '0;
                for (int s = 0; s < SLOTS; s++) begin
                    r_y[l][s] <= '0;
                end
            end
            r_hit  <= '0;
            r_miss <= '0;
            r_draw <= '0;
        end else begin
            r_valid <= w_valid_nx;
            r_y     <= w_y_nx;
            r_hit   <= w_hit_nx;
            r_miss  <= w_miss_nx;
            r_draw  <= w_draw_nx;
        end
    end

    assign o_hit_pulse  = r_hit;
    assign o_miss_pulse = r_miss;
    assign o_lane_draw  = r_draw;

`ifdef NOTE_ENGINE_SCORE_EN
    function automatic logic [15:0] popcount(input logic [LANES-1:0] v);
        logic [15:0] n;
        n = 16'd0;
        for (int i = 0; i < LANES; i++) begin
            n = n + {15'd0, v[i]};
        end
        return n;
    endfunction

    logic [15:0] r_score;
    logic [16:0] w_score_sum;

    // Score tracks the hit pulses as they are registered, so it moves together with o_hit_pulse.
    assign w_score_sum = {1'b0, r_score} + {1'b0, popcount(w_hit_nx)};

    // Saturating score accumulator.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_score <= 16'd0;
        end else begin
            r_score <= w_score_sum[16] ? 16'hFFFF : w_score_sum[15:0];
        end
    end

    assign o_score = r_score;
`else
    assign o_score = 16'd0;
`endif

endmodule

// File: tb/tb_note_lane_engine.sv
// Directed bench for note_lane_engine: two instances (hit bar at 350 and at 460) driven in lock-step and checked against a slot model.
module tb_note_lane_engine;
    localparam int LANES    = 4;
    localparam int SLOTS    = 4;
    localparam int SCREEN_H = 480;
    localparam int NOTE_H   = 50;
    localparam int HIT_H    = 20;
    localparam int SPEED    = 1;
    localparam int SPAWN_Y  = 0;
    localparam int ND       = 2;
`ifdef NOTE_ENGINE_SCORE_EN
    localparam logic [15:0] SC_ONE = 16'd1;
`else
    localparam logic [15:0] SC_ONE = 16'd0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       tick;
    logic       spawn_valid;
    logic [3:0] spawn_mask;
    logic [3:0] strum;
    logic [9:0] pix_y;
    logic       o_ready [ND];
    logic [3:0] o_draw  [ND];
    logic [3:0] o_hit   [ND];
    logic [3:0] o_miss  [ND];
    logic [15:0] o_score [ND];

    bit          m_valid [ND][LANES][SLOTS];
    int          m_y     [ND][LANES][SLOTS];
    logic [3:0]  e_draw  [ND];
    logic [3:0]  e_hit   [ND];
    logic [3:0]  e_miss  [ND];
    logic [15:0] e_score [ND];

    int n_chk = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    note_lane_engine #(.LANES(4), .SLOTS(4), .Y_WIDTH(10), .SCREEN_H(480), .SPAWN_Y(0),
                       .NOTE_H(50), .HIT_Y(350), .HIT_H(20), .SPEED(1)) u_dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_frame_tick(tick), .i_spawn_valid(spawn_valid),
        .i_spawn_mask(spawn_mask), .o_spawn_ready(o_ready[0]), .i_strum(strum), .i_pix_y(pix_y),
        .o_lane_draw(o_draw[0]), .o_hit_pulse(o_hit[0]), .o_miss_pulse(o_miss[0]), .o_score(o_score[0]));

    note_lane_engine #(.LANES(4), .SLOTS(4), .Y_WIDTH(10), .SCREEN_H(480), .SPAWN_Y(0),
                       .NOTE_H(50), .HIT_Y(460), .HIT_H(20), .SPEED(1)) u_dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_frame_tick(tick), .i_spawn_valid(spawn_valid),
        .i_spawn_mask(spawn_mask), .o_spawn_ready(o_ready[1]), .i_strum(strum), .i_pix_y(pix_y),
        .o_lane_draw(o_draw[1]), .o_hit_pulse(o_hit[1]), .o_miss_pulse(o_miss[1]), .o_score(o_score[1]));

    initial forever #5 clk = ~clk;

    function automatic int hit_y_of(int d);
        return (d == 0) ? 350 : 460;
    endfunction

    function automatic bit m_ready(int d);
        bit all_lanes;
        all_lanes = 1'b1;
        for (int l = 0; l < LANES; l++) begin
            int nfree;
            nfree = 0;
            for (int s = 0; s < SLOTS; s++) if (!m_valid[d][l][s]) nfree++;
            if (nfree == 0) all_lanes = 1'b0;
        end
        return all_lanes;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < ND; d++) begin
            for (int l = 0; l < LANES; l++)
                for (int s = 0; s < SLOTS; s++) begin
                    m_valid[d][l][s] = 1'b0;
                    m_y[d][l][s]     = 0;
                end
            e_draw[d] = 4'd0; e_hit[d] = 4'd0; e_miss[d] = 4'd0; e_score[d] = 16'd0;
        end
    endtask

    // One clock: evaluate the rules on the pre-edge state and inputs, then commit after the edge.
    task automatic step();
        bit          nv [ND][LANES][SLOTS];
        int          ny [ND][LANES][SLOTS];
        logic [3:0]  nd [ND];
        logic [3:0]  nh [ND];
        logic [3:0]  nm [ND];
        logic [15:0] ns [ND];
        nv = m_valid;
        ny = m_y;
        for (int d = 0; d < ND; d++) begin
            bit accept;
            int hy;
            int hits;
            accept = spawn_valid && m_ready(d);
            hy = hit_y_of(d);
            nd[d] = 4'd0; nh[d] = 4'd0; nm[d] = 4'd0;
            hits = 0;
            for (int l = 0; l < LANES; l++) begin
                int best;
                int free;
                best = -1;
                free = -1;
                for (int s = 0; s < SLOTS; s++) begin
                    int y;
                    y = m_y[d][l][s];
                    if (m_valid[d][l][s]) begin
                        if (y + NOTE_H > hy && y < hy + HIT_H && (best < 0 || y > m_y[d][l][best])) best = s;
                        if (y <= int'(pix_y) && int'(pix_y) < y + NOTE_H) nd[d][l] = 1'b1;
                    end else if (free < 0) begin
                        free = s;
                    end
                end
                if (strum[l] && best >= 0) begin
                    nv[d][l][best] = 1'b0;
                    nh[d][l] = 1'b1;
                    hits++;
                end else begin
                    best = -1;
                end
                if (tick) begin
                    for (int s = 0; s < SLOTS; s++) begin
                        if (m_valid[d][l][s] && s != best) begin
                            if (m_y[d][l][s] + SPEED >= SCREEN_H) begin
                                nv[d][l][s] = 1'b0;
                                nm[d][l] = 1'b1;
                            end else begin
                                ny[d][l][s] = m_y[d][l][s] + SPEED;
                            end
                        end
                    end
                end
                if (accept && spawn_mask[l] && free >= 0) begin
                    nv[d][l][free] = 1'b1;
                    ny[d][l][free] = SPAWN_Y;
                end
            end
`ifdef NOTE_ENGINE_SCORE_EN
            ns[d] = (int'(e_score[d]) + hits > 65535) ? 16'hFFFF : 16'(int'(e_score[d]) + hits);
`else
            ns[d] = 16'd0;
`endif
        end
        @(posedge clk);
        #1;
        if (!rst_n) begin
            model_reset();
        end else begin
            m_valid = nv;
            m_y     = ny;
            e_draw  = nd;
            e_hit   = nh;
            e_miss  = nm;
            e_score = ns;
        end
    endtask

    task automatic ticks(input int n);
        tick = 1'b1;
        repeat (n) step();
        tick = 1'b0;
    endtask

    // Per-cycle comparison of both instances against the model, away from the rising edge.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int d = 0; d < ND; d++) begin
                chk($sformatf("ready%0d", d), {15'd0, o_ready[d]}, {15'd0, m_ready(d)});
                chk($sformatf("draw%0d", d),  {12'd0, o_draw[d]},  {12'd0, e_draw[d]});
                chk($sformatf("hit%0d", d),   {12'd0, o_hit[d]},   {12'd0, e_hit[d]});
                chk($sformatf("miss%0d", d),  {12'd0, o_miss[d]},  {12'd0, e_miss[d]});
                chk($sformatf("score%0d", d), o_score[d], e_score[d]);
            end
        end
    end

    initial begin
        rst_n = 1'b0; tick = 1'b0; spawn_valid = 1'b0; spawn_mask = 4'd0; strum = 4'd0; pix_y = 10'd0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_en = 1'b1;
        chk("rst_ready", {15'd0, o_ready[0]}, 16'd1);
        chk("rst_draw", {12'd0, o_draw[0]}, 16'd0);
        step();
        rst_n = 1'b1;
        step();

        // Spawn lane 0, fall to 301 and query row 310; then to 320 and strum.
        spawn_valid = 1'b1; spawn_mask = 4'b0001; step();
        spawn_valid = 1'b0; spawn_mask = 4'b0000;
        pix_y = 10'd310;
        ticks(301);
        step();
        chk("draw_301", {12'd0, o_draw[0]}, 16'h0001);
        ticks(19);
        strum = 4'b0001; step(); strum = 4'b0000;
        chk("hit_320", {12'd0, o_hit[0]}, 16'h0001);
        chk("hit_320_dut1", {12'd0, o_hit[1]}, 16'h0000);
        chk("score_320", o_score[0], SC_ONE);
        strum = 4'b0001; step(); strum = 4'b0000;
        chk("hit_again", {12'd0, o_hit[0]}, 16'h0000);

        // Lane 1 falls unhit: no pulse at tick 479, pulse at tick 480.
        spawn_valid = 1'b1; spawn_mask = 4'b0010; step();
        spawn_valid = 1'b0; spawn_mask = 4'b0000;
        ticks(479);
        chk("miss_479", {12'd0, o_miss[0]}, 16'h0000);
        ticks(1);
        chk("miss_480", {12'd0, o_miss[0]}, 16'h0002);
        step();
        chk("miss_once", {12'd0, o_miss[0]}, 16'h0000);

        // Zero-mask spawn is a no-op.
        spawn_valid = 1'b1; spawn_mask = 4'b0000; step();
        spawn_valid = 1'b0;
        step();

        // Lane 2 at y=479, strum and tick together: hit on the 460 bar, miss on the 350 bar.
        spawn_valid = 1'b1; spawn_mask = 4'b0100; step();
        spawn_valid = 1'b0; spawn_mask = 4'b0000;
        ticks(479);
        tick = 1'b1; strum = 4'b0100; step(); tick = 1'b0; strum = 4'b0000;
        chk("edge_hit1", {12'd0, o_hit[1]}, 16'h0004);
        chk("edge_miss1", {12'd0, o_miss[1]}, 16'h0000);
        chk("edge_miss0", {12'd0, o_miss[0]}, 16'h0004);
        chk("edge_score1", o_score[1], SC_ONE);

        // Fill every lane, hold a rejected fifth spawn, then retire the oldest row.
        spawn_valid = 1'b1; spawn_mask = 4'b1111; step();
        spawn_valid = 1'b0;
        ticks(1);
        spawn_valid = 1'b1;
        repeat (3) step();
        chk("full_ready", {15'd0, o_ready[0]}, 16'd0);
        step();
        spawn_valid = 1'b0; spawn_mask = 4'b0000;
        chk("full_ready_held", {15'd0, o_ready[1]}, 16'd0);
        ticks(479);
        chk("row_miss", {12'd0, o_miss[0]}, 16'h000F);
        chk("row_ready", {15'd0, o_ready[0]}, 16'd1);

        // Reset in mid-cycle with notes on screen.
        pix_y = 10'd479;
        step();
        chk("pre_rst_draw", {12'd0, o_draw[0]}, 16'h000F);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("async_draw", {12'd0, o_draw[0]}, 16'h0000);
        chk("async_ready", {15'd0, o_ready[0]}, 16'd1);
        chk("async_score", o_score[1], 16'd0);
        step();
        rst_n = 1'b1;
        step();
        spawn_valid = 1'b1; spawn_mask = 4'b0001; step();
        spawn_valid = 1'b0; spawn_mask = 4'b0000;
        pix_y = 10'd0;
        step();
        chk("post_rst_draw", {12'd0, o_draw[0]}, 16'h0001);
        step();

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/note_lane_engine.md
# note_lane_engine

Parametrised falling-note state engine for the Guitar Hero display path. Holds up to SLOTS notes in each of LANES lanes and spawns new notes on a valid/ready handshake. Advances every live note on each frame tick, retires notes that leave the screen, and resolves player strums against a hit window. Sits between the song/note sequencer and the VGA pixel mux: the mux supplies the scan-line y and receives per-lane "draw note here" bits, while scoring logic consumes the hit/miss pulses.

## Interface
- LANES, 4, number of note lanes (1–8)
- SLOTS, 4, note slots per lane (1–8)
- Y_WIDTH, 10, width of a note's top-edge y coordinate
- SCREEN_H, 480, visible height; a note retires when its y reaches it
- SPAWN_Y, 0, y loaded into a newly spawned note
- NOTE_H, 50, note height in pixels
- HIT_Y, 350, top row of the hit bar
- HIT_H, 20, hit bar height
- SPEED, 1, pixels added per frame tick
- clk  in  1  system clock (100 MHz); all state on its rising edge
- reset  in  1  asynchronous, active-low; clears all state immediately
- frame_tick  in  1  one-cycle pulse per frame (synchronised screenEnd)
- spawn_valid  in  1  spawn request
- spawn_mask  in  LANES  lanes receiving a note in this spawn
- spawn_ready  out  1  high when every lane has at least one free slot
- strum  in  LANES  one-cycle hit-attempt pulse per lane
- pix_y  in  Y_WIDTH  current scan row for the draw query
- lane_draw  out  LANES  registered: pix_y lies inside a live note in that lane
- hit_pulse  out  LANES  one-cycle: strum consumed a note
- miss_pulse  out  LANES  one-cycle: note retired unhit
- score  out  16  hit score (see Configuration)

## Operation
- Per slot: valid bit plus unsigned y[Y_WIDTH-1:0]. Elaboration requires SCREEN_H+SPEED < 2^Y_WIDTH. All compares are done at Y_WIDTH+1 bits, so no wrap occurs.
- Spawn: a transfer occurs when spawn_valid & spawn_ready. For each lane with its spawn_mask bit set, the lowest-index free slot gets valid=1, y=SPAWN_Y. spawn_ready depends only on state, never on spawn_valid or spawn_mask. A transfer with an all-zero mask is accepted as a no-op.
- Move: on frame_tick, every valid slot takes y += SPEED. If the pre-move y+SPEED >= SCREEN_H, the slot is cleared instead and miss_pulse[l] is set for the next cycle. Multiple retirements in one lane produce a single pulse.
- In window: a slot is in window when y+NOTE_H > HIT_Y and y < HIT_Y+HIT_H.
- Strum on lane l: among valid in-window slots, the one with the largest y is cleared; ties go to the lowest index. hit_pulse[l] is set for the next cycle. A strum with no in-window note changes nothing.
- Draw: lane_draw[l] <= OR over valid slots of (y <= pix_y < y+NOTE_H).
- Simultaneous events, resolved in priority order on pre-cycle state:
  1. A strum-hit slot is cleared and neither moved nor retired; hit wins over retire, with no miss pulse.
  2. Other slots move or retire on frame_tick.
  3. A spawn uses only slots that were free before the cycle, is loaded at SPAWN_Y, and is not moved in its spawn cycle.
- Reset mid-operation discards all notes, pending pulses and the score.

## Timing
- Reset values: all valid=0, lane_draw=0, hit_pulse=0, miss_pulse=0, score=0. spawn_ready=1 while reset is asserted and after release.
- spawn_ready is combinational from slot state and updates the cycle after a spawn or retirement.
- hit_pulse and miss_pulse: registered, 1-cycle latency, high for exactly one cycle.
- lane_draw: 1-cycle latency from pix_y.
- score: updates in the cycle after the hit_pulse-causing strum.
- Back-to-back spawns are sustained every cycle until a lane fills.

## Configuration
- NOTE_ENGINE_SCORE_EN defined: a 16-bit score register adds the popcount of hit_pulse each cycle and saturates at 16'hFFFF. Strums are accepted as described.
- NOTE_ENGINE_SCORE_EN undefined: score is tied to 16'd0 and no score register is built. Hit/miss behaviour is unchanged.

## Test plan
- Reset release -> spawn_ready=1, all outputs 0. Spawn mask 4'b0001, then 301 frame_ticks with pix_y=310 -> lane_draw=4'b0001 one cycle later.
- Spawn mask 4'b0010 and apply no strum -> after 480 frame_ticks the slot clears and miss_pulse=4'b0010 for one cycle. No pulse on the 479th tick.
- Spawn lane 0, 320 ticks (y=320), strum=4'b0001 -> hit_pulse=4'b0001 next cycle, slot freed, score=1 with macro and 0 without. A second strum gives no pulse.
- Four spawns with mask 4'b1111 -> spawn_ready=0 and a fifth spawn_valid is not accepted. Retire one row -> spawn_ready=1.
- Note at y=479 with strum and frame_tick in the same cycle, HIT_Y=460 -> hit_pulse set and miss_pulse not set.
- Assert reset low mid-frame with three live notes -> all slots clear asynchronously and lane_draw=0 on the next edge.
